mul_cell_sequencer: RTL and testbench
=====================================

MUL_CELL_SEQUENCER -- requirements
Module: mul_cell_sequencer

Interface
REQ-001 SHALL have parameter CELL_LATENCY, default 1: cycles from cell_en/operands to valid cell_p1..p4.
REQ-002 SHALL have one clock and a synchronous, active-high reset (fixed).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 req0_valid / req1_valid  in  1 each  requester n has an operation pending.
REQ-006 req0_ready / req1_ready  out  1 each  accept pulse to requester n.
REQ-007 req0_op / req1_op  in  2 each  00 MUL (low word), 01 MULXSS, 10 MULXSU, 11 MULXUU (high words).
REQ-008 req0_src1, req0_src2, req1_src1, req1_src2  in  32 each  operands.
REQ-009 rsp_valid  out  1  result available.
REQ-010 rsp_ready  in  1  consumer takes result.
REQ-011 rsp_id  out  1  index of the requester that owns the result.
REQ-012 rsp_data  out  32  result word.
REQ-013 cell_src1, cell_src2  out  32 each  operands to the multiplier cell.
REQ-014 cell_src1_signed, cell_src2_signed  out  1 each  signedness controls to the cell.
REQ-015 cell_en  out  1  cell pipeline enable.
REQ-016 cell_p1..cell_p4  in  32 each  partial products: lo*lo, lo1*hi2, hi1*lo2, hi*hi.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> WAIT -> COMB -> RESP -> IDLE.
REQ-018 IDLE: if either reqN_valid, grant one requester, assert its reqN_ready for exactly that cycle, latch op/src1/src2/id, go to ISSUE.
REQ-019 Arbitration SHALL be round-robin: pointer starts at req0; after a grant to N, the pointer moves to the other requester; a lone valid requester is granted regardless of the pointer.
REQ-020 req0_ready and req1_ready SHALL never be high in the same cycle and SHALL be low outside IDLE.
REQ-021 ISSUE/WAIT: cell_src1/cell_src2 SHALL carry the latched operands, held stable; cell_en SHALL be high for exactly CELL_LATENCY cycles starting in ISSUE, then low, freezing the cell products.
REQ-022 Signedness: MUL 0/0, MULXSS 1/1, MULXSU 1/0, MULXUU 0/0 (src1_signed/src2_signed).
REQ-023 COMB (1 cycle): prod64 = zext(p1) + (ext(p2)<<16) + (ext(p3)<<16) + (p4<<32), modulo 2^64.
REQ-024 Extension rule: p2 sign-extended iff src2_signed; p3 sign-extended iff src1_signed; all others zero-extended.
REQ-025 rsp_data SHALL be registered: prod64[31:0] for MUL, prod64[63:32] otherwise.
REQ-026 rsp_valid SHALL rise exactly CELL_LATENCY+2 cycles after the accept cycle.
REQ-027 RESP: rsp_valid, rsp_id and rsp_data SHALL hold stable until the cycle with rsp_ready=1; that cycle SHALL be the last cycle of RESP, and the next cycle is IDLE.
REQ-028 New requests SHALL NOT be accepted while the FSM is outside IDLE (one operation in flight).
REQ-029 A reqN_valid dropped before its grant SHALL be ignored with no side effects.

Reset
REQ-030 On reset: state IDLE, round-robin pointer req0, all outputs 0 (ready, rsp_valid, rsp_id, rsp_data, cell_src*, cell_*_signed, cell_en).
REQ-031 Reset asserted mid-operation SHALL abort the operation with no response; the first accept is possible in the first cycle after reset is released.

Verification
REQ-032 req0 MUL 0x00010003 x 0x00020005 -> rsp_data 0x000B000F, rsp_id 0, rsp_valid at accept+3 (CELL_LATENCY=1).
REQ-033 0xFFFFFFFF x 0xFFFFFFFF: MULXSS -> 0x00000000; MULXUU -> 0xFFFFFFFE; MULXSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
REQ-034 Both requesters valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1; each granted exactly once per 2 operations; ready pulses never overlap.
REQ-035 rsp_ready held low 5 cycles in RESP -> rsp_* stable; no reqN_ready asserted; response consumed on the 6th cycle; IDLE on the next cycle.
REQ-036 Reset pulsed during WAIT -> no rsp_valid; all outputs 0; a new request is accepted in the first cycle after reset, with its result correct.
REQ-037 Randomized ops and operands over CELL_LATENCY in {1,2,3} -> rsp_data matches a 64-bit reference model per REQ-023..025; cell_en high for exactly CELL_LATENCY cycles per operation.

Source files
------------

// File: rtl/mul_cell_sequencer.sv
// Two-requester front end for an external pipelined 16x16 partial-product cell.
// Arbitrates requests, drives the cell, then recombines the four partial products into one result word.
module mul_cell_sequencer #(
  parameter int CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [1:0]  req0_op_i,
  input  logic [31:0] req0_src1_i,
  input  logic [31:0] req0_src2_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [1:0]  req1_op_i,
  input  logic [31:0] req1_src1_i,
  input  logic [31:0] req1_src2_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_data_o,
  output logic [31:0] cell_src1_o,
  output logic [31:0] cell_src2_o,
  output logic        cell_src1_signed_o,
  output logic        cell_src2_signed_o,
  output logic        cell_en_o,
  input  logic [31:0] cell_p1_i,
  input  logic [31:0] cell_p2_i,
  input  logic [31:0] cell_p3_i,
  input  logic [31:0] cell_p4_i
);

  localparam int CNT_W = (CELL_LATENCY > 1) ? $clog2(CELL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CELL_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMB,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULXSS = 2'b01,
    OP_MULXSU = 2'b10,
    OP_MULXUU = 2'b11
  } op_e;

  state_e           state_q;
  logic             rr_q;
  logic             hi_word_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cell_en_q;
  logic [31:0]      cell_src1_q;
  logic [31:0]      cell_src2_q;
  logic             src1_signed_q;
  logic             src2_signed_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [31:0]      rsp_data_q;

  logic             grant_vld;
  logic             grant_id;
  logic [1:0]       sel_op;
  logic [31:0]      sel_src1;
  logic [31:0]      sel_src2;

  logic [63:0]      p2_ext;
  logic [63:0]      p3_ext;
  logic [63:0]      prod64;
  logic [31:0]      rsp_data_d;

  // {src1_signed, src2_signed}; MULXUU is unsigned like MUL.
  function automatic logic [1:0] op_signedness(input logic [1:0] op);
    case (op_e'(op))
      OP_MULXSS: return 2'b11;
      OP_MULXSU: return 2'b10;
      default:   return 2'b00;
    endcase
  endfunction

  // Grant is combinational so a requester that drops valid before its grant is never taken.
  always_comb begin
    // NOTE: defaults first so every path assigns each signal; otherwise a latch is inferred.
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (!reset && state_q == S_IDLE) begin
      if (req0_valid_i && req1_valid_i) begin
        grant_vld = 1'b1;
        grant_id  = rr_q;
      end else if (req0_valid_i) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid_i) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign sel_op       = grant_id ? req1_op_i   : req0_op_i;
  assign sel_src1     = grant_id ? req1_src1_i : req0_src1_i;
  assign sel_src2     = grant_id ? req1_src2_i : req0_src2_i;
  assign req0_ready_o = grant_vld && !grant_id;
  assign req1_ready_o = grant_vld && grant_id;

  // The cross terms carry the sign of the high half they contain.
  always_comb begin
    p2_ext     = {{32{src2_signed_q & cell_p2_i[31]}}, cell_p2_i};
    p3_ext     = {{32{src1_signed_q & cell_p3_i[31]}}, cell_p3_i};
    prod64     = {32'd0, cell_p1_i} + (p2_ext << 16) + (p3_ext << 16) + {cell_p4_i, 32'd0};
    rsp_data_d = hi_word_q ? prod64[63:32] : prod64[31:0];
  end

  // NOTE: non-blocking assignments keep every register update order-independent within the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rr_q          <= 1'b0;
      hi_word_q     <= 1'b0;
      cnt_q         <= '0;
      cell_en_q     <= 1'b0;
      cell_src1_q   <= '0;
      cell_src2_q   <= '0;
      src1_signed_q <= 1'b0;
      src2_signed_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_data_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            rr_q                           <= ~grant_id;
            rsp_id_q                       <= grant_id;
            hi_word_q                      <= (sel_op != OP_MUL);
            {src1_signed_q, src2_signed_q} <= op_signedness(sel_op);
            cell_src1_q                    <= sel_src1;
            cell_src2_q                    <= sel_src2;
            cnt_q                          <= '0;
            cell_en_q                      <= 1'b1;
            state_q                        <= S_ISSUE;
          end
        end
        // cell_en stays high for CELL_LATENCY cycles; dropping it freezes the cell products.
        S_ISSUE, S_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            cell_en_q <= 1'b0;
            state_q   <= S_COMB;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_COMB: begin
          rsp_data_q  <= rsp_data_d;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid_o        = rsp_valid_q;
  assign rsp_id_o           = rsp_id_q;
  assign rsp_data_o         = rsp_data_q;
  assign cell_src1_o        = cell_src1_q;
  assign cell_src2_o        = cell_src2_q;
  assign cell_src1_signed_o = src1_signed_q;
  assign cell_src2_signed_o = src2_signed_q;
  assign cell_en_o          = cell_en_q;

endmodule

// File: tb/tb_mul_cell_sequencer.sv
// Bench for mul_cell_sequencer: three instances (CELL_LATENCY 1, 2, 3), each with a behavioural cell,
// checked against a full-width 64-bit multiply reference.
module tb_mul_cell_sequencer;

  localparam logic [1:0] MUL = 2'b00;
  localparam logic [1:0] XSS = 2'b01;
  localparam logic [1:0] XSU = 2'b10;
  localparam logic [1:0] XUU = 2'b11;

  logic clk = 1'b0;
  logic reset;
  logic [2:0]       r0v, r1v, rsprdy;
  logic [2:0][1:0]  r0op, r1op;
  logic [2:0][31:0] r0a, r0b, r1a, r1b;
  wire  [2:0]       r0rdy, r1rdy, rv, rid, cen, css1, css2;
  wire  [2:0][31:0] rdata, cs1, cs2;

  int checks = 0;
  int errors = 0;
  logic [31:0] got;

  always #5 clk = ~clk;

  // Partial products as the external cell forms them from 16-bit halves.
  function automatic logic [127:0] cell_pp(input logic [31:0] a, input logic [31:0] b,
                                           input logic sa, input logic sb);
    logic [63:0] lo1, hi1, lo2, hi2, p1, p2, p3, p4;
    lo1 = {48'd0, a[15:0]};
    hi1 = {{48{sa & a[31]}}, a[31:16]};
    lo2 = {48'd0, b[15:0]};
    hi2 = {{48{sb & b[31]}}, b[31:16]};
    p1 = lo1 * lo2;
    p2 = lo1 * hi2;
    p3 = hi1 * lo2;
    p4 = hi1 * hi2;
    return {p4[31:0], p3[31:0], p2[31:0], p1[31:0]};
  endfunction

  // Reference: extend both operands to 64 bits and multiply.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = {{32{((op == XSS) || (op == XSU)) & a[31]}}, a};
    eb = {{32{(op == XSS) & b[31]}}, b};
    p  = ea * eb;
    return (op == MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_FFFF;
      5: return 32'hFFFF_8000;
      default: return $urandom();
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int L = g + 1;
    logic [127:0] pipe [L];
    logic [31:0]  p1, p2, p3, p4;

    assign {p4, p3, p2, p1} = pipe[L-1];

    always @(posedge clk) begin
      if (cen[g]) begin
        pipe[0] <= cell_pp(cs1[g], cs2[g], css1[g], css2[g]);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
    end

    mul_cell_sequencer #(.CELL_LATENCY(L)) u_dut (
      .clk               (clk),
      .reset             (reset),
      .req0_valid_i      (r0v[g]),
      .req0_ready_o      (r0rdy[g]),
      .req0_op_i         (r0op[g]),
      .req0_src1_i       (r0a[g]),
      .req0_src2_i       (r0b[g]),
      .req1_valid_i      (r1v[g]),
      .req1_ready_o      (r1rdy[g]),
      .req1_op_i         (r1op[g]),
      .req1_src1_i       (r1a[g]),
      .req1_src2_i       (r1b[g]),
      .rsp_valid_o       (rv[g]),
      .rsp_ready_i       (rsprdy[g]),
      .rsp_id_o          (rid[g]),
      .rsp_data_o        (rdata[g]),
      .cell_src1_o       (cs1[g]),
      .cell_src2_o       (cs2[g]),
      .cell_src1_signed_o(css1[g]),
      .cell_src2_signed_o(css2[g]),
      .cell_en_o         (cen[g]),
      .cell_p1_i         (p1),
      .cell_p2_i         (p2),
      .cell_p3_i         (p3),
      .cell_p4_i         (p4)
    );
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input int k, input string tag);
    chk($sformatf("k%0d_%s_ctrl", k, tag),
        128'({r0rdy[k], r1rdy[k], rv[k], rid[k], cen[k], css1[k], css2[k]}), 128'(0));
    chk($sformatf("k%0d_%s_data", k, tag), 128'({rdata[k], cs1[k], cs2[k]}), 128'(0));
  endtask

  // One full transaction on instance k; optionally keeps the other requester valid while busy.
  task automatic run_op(input int k, input logic rq, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input logic noise, output logic [31:0] obs);
    logic [31:0] exp;
    logic exp_s1, exp_s2, rdy, src_bad, rdy_bad;
    int lat, en, cyc;
    exp    = ref_mul(op, a, b);
    exp_s1 = (op == XSS) || (op == XSU);
    exp_s2 = (op == XSS);
    rsprdy[k] = 1'b0;
    if (rq) begin
      r1op[k] = op; r1a[k] = a; r1b[k] = b; r1v[k] = 1'b1;
    end else begin
      r0op[k] = op; r0a[k] = a; r0b[k] = b; r0v[k] = 1'b1;
    end
    #1;
    rdy = rq ? r1rdy[k] : r0rdy[k];
    chk($sformatf("k%0d_accept", k), 128'(rdy), 128'(1'b1));
    chk($sformatf("k%0d_ready_excl", k), 128'(r0rdy[k] & r1rdy[k]), 128'(1'b0));
    cyc = 0;
    while (rdy !== 1'b1 && cyc < 20) begin
      tick();
      rdy = rq ? r1rdy[k] : r0rdy[k];
      cyc++;
    end
    tick();
    if (rq) r1v[k] = 1'b0; else r0v[k] = 1'b0;
    if (noise) begin
      if (rq) begin
        r0op[k] = XSS; r0a[k] = ~a; r0b[k] = ~b; r0v[k] = 1'b1;
      end else begin
        r1op[k] = XSS; r1a[k] = ~a; r1b[k] = ~b; r1v[k] = 1'b1;
      end
    end
    #1;
    chk($sformatf("k%0d_cell_in", k), 128'({css1[k], css2[k], cs1[k], cs2[k]}),
        128'({exp_s1, exp_s2, a, b}));
    lat = 1; en = 0; src_bad = 1'b0; rdy_bad = 1'b0;
    while (rv[k] !== 1'b1 && lat < 20) begin
      if (cen[k]) begin
        en++;
        if (cs1[k] !== a || cs2[k] !== b) src_bad = 1'b1;
      end
      if (r0rdy[k] | r1rdy[k]) rdy_bad = 1'b1;
      tick();
      lat++;
    end
    if (r0rdy[k] | r1rdy[k]) rdy_bad = 1'b1;
    chk($sformatf("k%0d_latency", k), 128'(lat), 128'(k + 3));
    chk($sformatf("k%0d_cell_en_cycles", k), 128'(en), 128'(k + 1));
    chk($sformatf("k%0d_src_stable", k), 128'(src_bad), 128'(1'b0));
    chk($sformatf("k%0d_rsp op=%0d a=%h b=%h", k, op, a, b), 128'({rid[k], rdata[k]}), 128'({rq, exp}));
    obs = rdata[k];
    for (int i = 0; i < hold; i++) begin
      tick();
      if (r0rdy[k] | r1rdy[k]) rdy_bad = 1'b1;
      chk($sformatf("k%0d_rsp_hold%0d", k, i), 128'({rv[k], rid[k], rdata[k]}), 128'({1'b1, rq, exp}));
    end
    chk($sformatf("k%0d_no_ready_busy", k), 128'(rdy_bad), 128'(1'b0));
    rsprdy[k] = 1'b1;
    tick();
    rsprdy[k] = 1'b0;
    chk($sformatf("k%0d_consumed", k), 128'(rv[k]), 128'(1'b0));
    if (noise) begin
      chk($sformatf("k%0d_idle_after_rsp", k), 128'(rq ? r0rdy[k] : r1rdy[k]), 128'(1'b1));
      if (rq) r0v[k] = 1'b0; else r1v[k] = 1'b0;
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        rq, noise, overlap;
    logic [3:0]  gseq, iseq;
    int          hold, gcnt, rcnt, c;

    reset = 1'b1;
    r0v = '0; r1v = '0; rsprdy = '0;
    r0op = '0; r1op = '0; r0a = '0; r0b = '0; r1a = '0; r1b = '0;
    r0v[0] = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) check_zero(k, "reset");
    r0v[0] = 1'b0;
    reset = 1'b0;

    // Directed results on CELL_LATENCY=1.
    run_op(0, 1'b0, MUL, 32'h0001_0003, 32'h0002_0005, 0, 1'b0, got);
    chk("mul_basic", 128'(got), 128'(32'h000B_000F));
    run_op(0, 1'b1, XSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, got);
    chk("mulxss_m1", 128'(got), 128'(32'h0000_0000));
    run_op(0, 1'b0, XUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, got);
    chk("mulxuu_max", 128'(got), 128'(32'hFFFF_FFFE));
    run_op(0, 1'b1, XSU, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1'b0, got);
    chk("mulxsu_m1x2", 128'(got), 128'(32'hFFFF_FFFF));

    // Back-pressure: response held 5 cycles while the other requester waits.
    run_op(0, 1'b0, XSS, 32'h8000_0000, 32'h7FFF_FFFF, 5, 1'b1, got);

    // Round-robin with both requesters valid continuously after reset.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    r0op[0] = MUL; r0a[0] = 32'h0000_1234; r0b[0] = 32'h0000_0010;
    r1op[0] = XUU; r1a[0] = 32'hFFFF_FFFF; r1b[0] = 32'hFFFF_FFFF;
    r0v[0] = 1'b1; r1v[0] = 1'b1; rsprdy[0] = 1'b1;
    #1;
    gseq = 4'bxxxx; iseq = 4'bxxxx; gcnt = 0; rcnt = 0; overlap = 1'b0; c = 0;
    while (rcnt < 4 && c < 80) begin
      if (r0rdy[0] & r1rdy[0]) overlap = 1'b1;
      if (r0rdy[0] | r1rdy[0]) begin
        if (gcnt < 4) gseq[3-gcnt] = r1rdy[0];
        gcnt++;
      end
      if (rv[0]) begin
        iseq[3-rcnt] = rid[0];
        chk($sformatf("alt_data%0d", rcnt), 128'(rdata[0]),
            128'((rcnt % 2 == 1) ? ref_mul(XUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF)
                                 : ref_mul(MUL, 32'h0000_1234, 32'h0000_0010)));
        rcnt++;
      end
      tick();
      c++;
    end
    r0v[0] = 1'b0; r1v[0] = 1'b0; rsprdy[0] = 1'b0;
    chk("alt_grants", 128'(gseq), 128'(4'b0101));
    chk("alt_rsp_ids", 128'(iseq), 128'(4'b0101));
    chk("alt_grant_count", 128'(gcnt), 128'(4));
    chk("alt_no_overlap", 128'(overlap), 128'(1'b0));

    // Reset pulsed while the CELL_LATENCY=3 instance is in WAIT.
    tick();
    r0op[2] = XSS; r0a[2] = 32'h1234_5678; r0b[2] = 32'h9ABC_DEF0; r0v[2] = 1'b1;
    #1;
    chk("k2_rw_accept", 128'(r0rdy[2]), 128'(1'b1));
    tick();
    r0v[2] = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check_zero(2, "reset_in_wait");
    reset = 1'b0;
    run_op(2, 1'b1, XSU, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1, 1'b0, got);

    // Randomized operations on every latency.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 12; n++) begin
        op    = 2'($urandom_range(0, 3));
        a     = pick();
        b     = pick();
        rq    = 1'($urandom_range(0, 1));
        hold  = int'($urandom_range(0, 2));
        noise = 1'($urandom_range(0, 1));
        run_op(k, rq, op, a, b, hold, noise, got);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
